instruction_fetch: RTL

//  Fetch stage ahead of the instruction decoder. Holds the program counter and issues
//  16-bit instruction reads to instruction memory over a req/ready handshake.

---
 rtl/instruction_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage in front of the instruction decoder. Owns the program counter,
//   issues 16-bit word reads to instruction memory and presents each fetched
//   word, with a valid flag and the PC it came from, to the decoder. Handles
//   downstream stall and branch/jump redirect (the held word is flushed to NOP).
//
// Ports
//   clk              in   1   clock, all state on posedge
//   rst              in   1   asynchronous active-high reset
//   stall            in   1   decoder cannot accept; hold current output
//   redirect         in   1   branch/jump taken this cycle
//   redirectTarget   in   16  new PC when redirect=1
//   memAddr          out  16  instruction memory word address (= pc)
//   memRead          out  1   read request
//   memData          in   16  read data, qualified by memReady
//   memReady         in   1   one-cycle read completion strobe
//   instruction      out  16  fetched word (NOP_WORD when nothing is held)
//   instructionValid out  1   instruction holds a real fetched word
//   instructionPC    out  16  address the held word was fetched from
//   o_dbg_state      out  2   FSM state (0=BOOT, 1=RUN, 2=FLUSH)
//
// Memory handshake (valid/ready):
//   A read transfers on a posedge where memRead=1 and memReady=1. memAddr is
//   pc and stays put while memRead=1 until memReady. memRead may drop without
//   memReady (stall or redirect); that abandons the request. memReady while
//   memRead=0 is ignored.
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_WORD = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirectTarget,
   output logic [15:0] memAddr,
   output logic        memRead,
   input  logic [15:0] memData,
   input  logic        memReady,
   output logic [15:0] instruction,
   output logic        instructionValid,
   output logic [15:0] instructionPC,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_pc;
   logic [15:0] r_instr;
   logic        r_valid;
   logic [15:0] r_instr_pc;
   logic        w_mem_read;
   logic        w_fire;
   logic        w_consume;

   // Next state and read request. A new read is only issued when the output
   // register will be free at the next edge (empty, or consumed this cycle).
   always_comb begin
      w_state_next = r_state;
      w_mem_read   = 1'b0;
      case (r_state)
         ST_BOOT:  w_state_next = ST_RUN;
         ST_RUN: begin
            w_state_next = ST_RUN;
            w_mem_read   = !redirect && (!r_valid || !stall);
         end
         ST_FLUSH: w_state_next = ST_RUN;
         default:  w_state_next = ST_BOOT;
      endcase
      // Redirect wins in every state.
      if (redirect) begin
         w_state_next = ST_FLUSH;
      end
   end

   assign w_fire    = w_mem_read && memReady;
   assign w_consume = r_valid && !stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_PC;
         r_instr    <= NOP_WORD;
         r_valid    <= 1'b0;
         r_instr_pc <= 16'h0000;
      end else begin
         r_state <= w_state_next;
         if (redirect) begin
            // Any same-cycle memReady data is dropped here.
            r_pc    <= redirectTarget;
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
         end else if (w_fire) begin
            r_instr    <= memData;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + 16'h0001;  // wraps FFFF -> 0000
         end else if (w_consume) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
         end
      end
   end

   assign memAddr          = r_pc;
   assign memRead          = w_mem_read;
   assign instruction      = r_instr;
   assign instructionValid = r_valid;
   assign instructionPC    = r_instr_pc;
   assign o_dbg_state      = r_state;

endmodule
